adbg_tap_ctrl: RTL and testbench
================================

// Module: adbg_tap_ctrl
// PURPOSE
//  IEEE 1149.1 TAP controller driving the advanced debug interface top from the TAP side.
//  Runs the 16-state TAP FSM and holds the instruction register, IDCODE and BYPASS registers.
//  Exports the DR state strobes (capture/shift/pause/update) and debug_select_o.
//  Muxes the debug-top TDO onto the JTAG TDO pin.
// PARAMETERS
//  IR_LENGTH     4             instruction register width (>=2)
//  IDCODE_VALUE  32'h149511C3  value shifted out by the IDCODE instruction (bit0 must be 1)
//  IDCODE_INSTR  4'h2          IR code selecting IDCODE
//  DEBUG_INSTR   4'h8          IR code selecting the debug chain (asserts debug_select_o)
//  BYPASS_INSTR  4'hF          IR code selecting BYPASS; every unlisted code also selects BYPASS
// PORTS
//  tck_i               in   1  JTAG test clock
//  trstn_i             in   1  reset: asynchronous, active-low
//  tms_i               in   1  test mode select, sampled on rising tck_i
//  tdi_i               in   1  test data in, sampled on rising tck_i
//  tdo_o               out  1  test data out, updated on falling tck_i
//  tdo_oe_o            out  1  TDO output enable, updated on falling tck_i
//  debug_tdo_i         in   1  serial output of the debug top (its tdo_o)
//  test_logic_reset_o  out  1  high while FSM is in Test-Logic-Reset
//  capture_dr_o        out  1  high while FSM is in Capture-DR
//  shift_dr_o          out  1  high while FSM is in Shift-DR
//  pause_dr_o          out  1  high while FSM is in Pause-DR
//  update_dr_o         out  1  high while FSM is in Update-DR
//  debug_select_o      out  1  high while latched IR == DEBUG_INSTR
// BEHAVIOUR
//  Reset (trstn_i low, async): FSM=TEST_LOGIC_RESET, latched IR=IDCODE_INSTR, IR shift reg=0.
//    Also clears IDCODE shift reg, bypass bit, tdo_o=0 and tdo_oe_o=0.
//    Outputs during reset: test_logic_reset_o=1, all DR strobes=0, debug_select_o=0.
//  FSM: 16 standard 1149.1 states, next state on rising tck_i from tms_i.
//    TLR -0-> RTI, TLR -1-> TLR; RTI -1-> SEL_DR; SEL_DR -0-> CAP_DR, SEL_DR -1-> SEL_IR;
//    SEL_IR -0-> CAP_IR, SEL_IR -1-> TLR; CAP_x -0-> SHIFT_x, CAP_x -1-> EXIT1_x;
//    SHIFT_x -1-> EXIT1_x; EXIT1_x -0-> PAUSE_x, EXIT1_x -1-> UPD_x; PAUSE_x -1-> EXIT2_x;
//    EXIT2_x -0-> SHIFT_x, EXIT2_x -1-> UPD_x; UPD_x -0-> RTI, UPD_x -1-> SEL_DR.
//    All other (state, tms) pairs hold the current state.
//  Five consecutive tms_i=1 edges reach TLR from any state.
//  Entering TLR synchronously forces latched IR=IDCODE_INSTR.
//  DR strobes/test_logic_reset_o: pure decode of the registered state, no extra latency.
//    This allows the debug top to act on the same rising edge that leaves the state.
//  IR path, on rising tck_i:
//    CAP_IR: IR shift reg <= {0..,2'b01}.
//    SHIFT_IR: IR shift reg <= {tdi_i, ir[IR_LENGTH-1:1]}, LSB first.
//    UPD_IR: latched IR <= IR shift reg.
//    A new instruction takes effect from the first cycle after Update-IR.
//  IDCODE path: CAP_DR && IR==IDCODE loads IDCODE_VALUE; SHIFT_DR shifts right, tdi_i into bit31.
//  BYPASS path: CAP_DR loads 0; SHIFT_DR loads tdi_i. Gives one-bit delay, first captured bit 0.
//  TDO mux (falling tck_i):
//    In SHIFT_IR: ir_shift[0].
//    In SHIFT_DR: selected DR LSB (IDCODE/debug_tdo_i/bypass).
//    Otherwise tdo_o holds its last value.
//    tdo_oe_o=1 only in SHIFT_IR/SHIFT_DR (also registered on falling edge).
//  debug_tdo_i is forwarded in SHIFT_DR only when IR==DEBUG_INSTR.
//  debug_select_o stays asserted through IR capture/shift; it changes only at Update-IR or TLR.
//  Reset mid-shift: all state clears at once; partial IR/DR contents are discarded.
//  Nothing is latched in that case.
// TESTING
//  1 trstn pulse, then TMS=1x5 -> FSM TLR, test_logic_reset_o=1, debug_select_o=0, IR=IDCODE.
//  2 After reset, go to SHIFT_DR and shift 32 bits.
//    -> TDO returns 32'h149511C3 LSB first; tdo_oe_o=1 only during those 32 cycles.
//  3 SHIFT_IR with tdi=4'h8, then Update-IR -> first 4 TDO bits 1,0,0,0 (capture 01).
//    -> debug_select_o=1 starting the cycle after UPD_IR.
//  4 IR=DEBUG: CAP_DR->SHIFT_DR x64->EXIT1->UPD_DR.
//    -> capture/shift/update strobes high in the exact states.
//    -> tdo_o equals debug_tdo_i delayed half a cycle.
//  5 IR=4'h5 (unlisted): shift 8 bits 10110011 -> TDO gives 0 then tdi delayed by one tck.
//  6 Assert trstn_i mid SHIFT_IR after 2 bits -> immediate TLR.
//    -> tdo_oe_o=0; IR stays IDCODE; no update occurs.

Source files
------------

// File: rtl/adbg_tap_ctrl.sv
// IEEE 1149.1 TAP controller for the advanced debug interface.
// Holds the IR, IDCODE and BYPASS registers and muxes the debug chain onto TDO.
module adbg_tap_ctrl #(
    parameter int unsigned          IR_LENGTH    = 4,
    parameter logic [31:0]          IDCODE_VALUE = 32'h149511C3,
    parameter logic [IR_LENGTH-1:0] IDCODE_INSTR = 4'h2,
    parameter logic [IR_LENGTH-1:0] DEBUG_INSTR  = 4'h8,
    parameter logic [IR_LENGTH-1:0] BYPASS_INSTR = 4'hF
) (
    input  logic tck_i,
    input  logic trstn_i,
    input  logic tms_i,
    input  logic tdi_i,
    output logic tdo_o,
    output logic tdo_oe_o,
    input  logic debug_tdo_i,
    output logic test_logic_reset_o,
    output logic capture_dr_o,
    output logic shift_dr_o,
    output logic pause_dr_o,
    output logic update_dr_o,
    output logic debug_select_o
);

    // state    | meaning
    // TLR      | Test-Logic-Reset, IR forced to IDCODE
    // RTI      | Run-Test/Idle
    // SEL_x    | Select-DR/IR-Scan
    // CAP_x    | Capture-DR/IR, parallel load of the shift register
    // SHIFT_x  | Shift-DR/IR, LSB first on TDO
    // EXIT1/2_x| Exit1/Exit2 around the pause state
    // PAUSE_x  | Pause-DR/IR, shifting suspended
    // UPD_x    | Update-DR/IR, IR latched in UPD_IR
    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
        SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
    } tap_state_e;

    localparam logic [IR_LENGTH-1:0] IR_CAPTURE = {{(IR_LENGTH-1){1'b0}}, 1'b1};

    tap_state_e           state_q, state_d;
    logic [IR_LENGTH-1:0] ir_shift_q;
    logic [IR_LENGTH-1:0] ir_latched_q;
    logic [31:0]          idcode_sr_q;
    logic                 bypass_q;
    logic                 sel_idcode;
    logic                 dr_tdo;

    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:      state_d = tms_i ? TLR      : RTI;
            RTI:      if (tms_i) state_d = SEL_DR;
            SEL_DR:   state_d = tms_i ? SEL_IR   : CAP_DR;
            CAP_DR:   state_d = tms_i ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR: if (tms_i) state_d = EXIT1_DR;
            EXIT1_DR: state_d = tms_i ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: if (tms_i) state_d = EXIT2_DR;
            EXIT2_DR: state_d = tms_i ? UPD_DR   : SHIFT_DR;
            UPD_DR:   state_d = tms_i ? SEL_DR   : RTI;
            SEL_IR:   state_d = tms_i ? TLR      : CAP_IR;
            CAP_IR:   state_d = tms_i ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR: if (tms_i) state_d = EXIT1_IR;
            EXIT1_IR: state_d = tms_i ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: if (tms_i) state_d = EXIT2_IR;
            EXIT2_IR: state_d = tms_i ? UPD_IR   : SHIFT_IR;
            UPD_IR:   state_d = tms_i ? SEL_DR   : RTI;
            default:  state_d = TLR;
        endcase
    end

    always_ff @(posedge tck_i or negedge trstn_i) begin
        if (!trstn_i) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    // IR latch is forced on the edge that enters TLR so debug_select_o drops with the state.
    always_ff @(posedge tck_i or negedge trstn_i) begin
        if (!trstn_i) begin
            ir_shift_q   <= '0;
            ir_latched_q <= IDCODE_INSTR;
        end else begin
            if (state_q == CAP_IR) begin
                ir_shift_q <= IR_CAPTURE;
            end else if (state_q == SHIFT_IR) begin
                ir_shift_q <= {tdi_i, ir_shift_q[IR_LENGTH-1:1]};
            end
            if (state_d == TLR) begin
                ir_latched_q <= IDCODE_INSTR;
            end else if (state_q == UPD_IR) begin
                ir_latched_q <= ir_shift_q;
            end
        end
    end

    assign sel_idcode = (ir_latched_q == IDCODE_INSTR);

    always_ff @(posedge tck_i or negedge trstn_i) begin
        if (!trstn_i) begin
            idcode_sr_q <= '0;
            bypass_q    <= 1'b0;
        end else begin
            if (state_q == CAP_DR && sel_idcode) begin
                idcode_sr_q <= IDCODE_VALUE;
            end else if (state_q == SHIFT_DR && sel_idcode) begin
                idcode_sr_q <= {tdi_i, idcode_sr_q[31:1]};
            end
            if (state_q == CAP_DR) begin
                bypass_q <= 1'b0;
            end else if (state_q == SHIFT_DR) begin
                bypass_q <= tdi_i;
            end
        end
    end

    always_comb begin
        dr_tdo = bypass_q;
        case (ir_latched_q)
            IDCODE_INSTR: dr_tdo = idcode_sr_q[0];
            DEBUG_INSTR:  dr_tdo = debug_tdo_i;
            BYPASS_INSTR: dr_tdo = bypass_q;
            default:      dr_tdo = bypass_q;
        endcase
    end

    always_ff @(negedge tck_i or negedge trstn_i) begin
        if (!trstn_i) begin
            tdo_o    <= 1'b0;
            tdo_oe_o <= 1'b0;
        end else begin
            tdo_oe_o <= (state_q == SHIFT_IR) || (state_q == SHIFT_DR);
            if (state_q == SHIFT_IR) begin
                tdo_o <= ir_shift_q[0];
            end else if (state_q == SHIFT_DR) begin
                tdo_o <= dr_tdo;
            end
        end
    end

    assign test_logic_reset_o = (state_q == TLR);
    assign capture_dr_o       = (state_q == CAP_DR);
    assign shift_dr_o         = (state_q == SHIFT_DR);
    assign pause_dr_o         = (state_q == PAUSE_DR);
    assign update_dr_o        = (state_q == UPD_DR);
    assign debug_select_o     = (ir_latched_q == DEBUG_INSTR);

endmodule

// File: tb/tb_adbg_tap_ctrl.sv
// Directed bench for adbg_tap_ctrl: expected TDO bits are queued as stimulus is
// driven and popped whenever the DUT enables TDO.
module tb_adbg_tap_ctrl;

    logic tck = 1'b0;
    logic trstn = 1'b0;
    logic tms = 1'b1;
    logic tdi = 1'b0;
    logic dbg = 1'b0;
    logic tdo, tdo_oe, tlr, cap, sh, pa, up, dsel;

    int   n_cmp = 0;
    int   n_err = 0;
    int   oe_cnt = 0;
    logic exp_q[$];
    logic [31:0] idv = 32'h149511C3;
    logic [7:0]  pat = 8'b10110011;
    logic        last_dbg;

    adbg_tap_ctrl dut (
        .tck_i(tck), .trstn_i(trstn), .tms_i(tms), .tdi_i(tdi),
        .tdo_o(tdo), .tdo_oe_o(tdo_oe), .debug_tdo_i(dbg),
        .test_logic_reset_o(tlr), .capture_dr_o(cap), .shift_dr_o(sh),
        .pause_dr_o(pa), .update_dr_o(up), .debug_select_o(dsel)
    );

    always #5 tck = ~tck;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check5(input string tag, input logic [4:0] exp);
        n_cmp++;
        assert ({tlr, cap, sh, pa, up} === exp) else begin
            n_err++;
            $error("FAIL %s: observed tlr/cap/sh/pa/up %b expected %b", tag, {tlr, cap, sh, pa, up}, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One TCK cycle; outputs are sampled just after the falling edge.
    task automatic tap(input logic t_ms, input logic t_di);
        tms = t_ms;
        tdi = t_di;
        @(posedge tck);
        @(negedge tck);
        #1;
        if (tdo_oe) begin
            oe_cnt++;
            if (exp_q.size() == 0) check("tdo_oe_unexpected", tdo_oe, 1'b0);
            else check("tdo", tdo, exp_q.pop_front());
        end
    endtask

    task automatic load_ir(input logic [3:0] v, input logic dsel_before);
        oe_cnt = 0;
        tap(1, 0); tap(1, 0); tap(0, 0);
        exp_q.push_back(1'b1);
        tap(0, 0);
        for (int i = 0; i < 4; i++) begin
            if (i < 3) exp_q.push_back(1'b0);
            tap(i == 3, v[i]);
        end
        tap(1, 0);
        check("dsel_at_upd_ir", dsel, dsel_before);
        tap(0, 0);
        check("dsel_after_upd_ir", dsel, v == 4'h8);
        check_int("ir_oe_cycles", oe_cnt, 4);
        check_int("ir_queue_empty", exp_q.size(), 0);
    endtask

    task automatic read_idcode();
        oe_cnt = 0;
        tap(1, 0);
        tap(0, 0);
        check5("cap_dr_idcode", 5'b01000);
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(idv[i]);
            tap(0, 1'($urandom_range(0, 1)));
        end
        tap(1, 0);
        check("idcode_oe_exit1", tdo_oe, 1'b0);
        tap(1, 0);
        tap(0, 0);
        check_int("idcode_oe_cycles", oe_cnt, 32);
        check_int("idcode_queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset, then TMS=1 x5
        #22;
        check5("reset_strobes", 5'b10000);
        check("reset_dsel", dsel, 1'b0);
        check("reset_oe", tdo_oe, 1'b0);
        check("reset_tdo", tdo, 1'b0);
        trstn = 1'b1;
        repeat (5) tap(1, 0);
        check5("tlr_after_tms5", 5'b10000);
        check("tlr_dsel", dsel, 1'b0);

        // 2: IDCODE readout
        tap(0, 0);
        check5("rti_strobes", 5'b00000);
        read_idcode();

        // 3: load DEBUG instruction
        load_ir(4'h8, 1'b0);

        // 4: debug chain pass-through with 64 shifts
        oe_cnt = 0;
        tap(1, 0);
        check("dsel_sel_dr", dsel, 1'b1);
        tap(0, 0);
        check5("dbg_cap_dr", 5'b01000);
        for (int i = 0; i < 64; i++) begin
            dbg = 1'($urandom_range(0, 1));
            exp_q.push_back(dbg);
            tap(0, 0);
            check5("dbg_shift_dr", 5'b00100);
        end
        last_dbg = dbg;
        dbg = ~dbg;
        tap(1, 0);
        check5("dbg_exit1", 5'b00000);
        check("dbg_tdo_hold", tdo, last_dbg);
        check("dbg_oe_exit1", tdo_oe, 1'b0);
        tap(1, 0);
        check5("dbg_upd_dr", 5'b00001);
        tap(0, 0);
        check5("dbg_rti", 5'b00000);
        check_int("dbg_oe_cycles", oe_cnt, 64);
        check_int("dbg_queue_empty", exp_q.size(), 0);

        // 5: unlisted code 4'h5 selects BYPASS
        load_ir(4'h5, 1'b1);
        oe_cnt = 0;
        tap(1, 0);
        tap(0, 0);
        exp_q.push_back(1'b0);
        tap(0, 0);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(pat[7-i]);
            tap(0, pat[7-i]);
        end
        tap(1, 0);
        tap(0, 0);
        check5("byp_pause_dr", 5'b00010);
        tap(0, 0);
        check5("byp_pause_hold", 5'b00010);
        tap(1, 0);
        tap(1, 0);
        check5("byp_upd_dr", 5'b00001);
        tap(0, 0);
        check_int("byp_oe_cycles", oe_cnt, 9);
        check_int("byp_queue_empty", exp_q.size(), 0);

        // TLR must drop a DEBUG instruction
        load_ir(4'h8, 1'b0);
        repeat (5) tap(1, 0);
        check5("tlr_from_debug", 5'b10000);
        check("tlr_clears_dsel", dsel, 1'b0);

        // 6: trstn mid SHIFT_IR after 2 bits, shifting in DEBUG's low bits
        tap(0, 0);
        tap(1, 0); tap(1, 0); tap(0, 0);
        exp_q.push_back(1'b1);
        tap(0, 0);
        exp_q.push_back(1'b0);
        tap(0, 0);
        exp_q.push_back(1'b0);
        tap(0, 0);
        trstn = 1'b0;
        #1;
        check5("trst_mid_shift", 5'b10000);
        check("trst_oe", tdo_oe, 1'b0);
        check("trst_tdo", tdo, 1'b0);
        check("trst_dsel", dsel, 1'b0);
        tap(0, 0);
        check5("trst_held", 5'b10000);
        trstn = 1'b1;
        tap(0, 0);
        check("post_trst_dsel", dsel, 1'b0);
        check_int("trst_queue_empty", exp_q.size(), 0);
        read_idcode();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
